// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage widths, reset PC, NOP word and FSM encodings
// The S_DISCARD state exists only when IF_REDIRECT_EN is defined.
package if_stage_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 64;
    localparam int FIFO_DEPTH  = 2;
    localparam int FIFO_W      = INST_ADDR_W + INST_W;

    localparam logic [INST_ADDR_W-1:0] START_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0]      NOP_INST = 64'h0;
    localparam logic [INST_ADDR_W-1:0] PC_STEP  = 32'd8;

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_FETCH   = 2'd1,
        S_FULL    = 2'd2
`ifdef IF_REDIRECT_EN
        ,
        S_DISCARD = 2'd3
`endif
    } state_t;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] align8(input logic [INST_ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFF8;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - small {pc, inst} response FIFO with push/pop/flush and occupancy count
// Pointers wrap naturally, so DEPTH must be a power of two.
module if_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = FIFO_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = push & ~w_full;
    assign w_do_pop  = pop & (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= r_wr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd];
    assign empty = (r_count == '0);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: one outstanding imem request, 2-entry response buffer
// Define IF_REDIRECT_EN to add redirect_i/redirect_pc_i and the S_DISCARD state.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
`ifdef IF_REDIRECT_EN
    input  logic                   redirect_i,
    input  logic [INST_ADDR_W-1:0] redirect_pc_i,
`endif
    input  logic                   stall_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic                   if_valid_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o
);

    state_t                 r_state;
    state_t                 w_next;
    logic [INST_ADDR_W-1:0] r_pc;

    logic                   w_redirect;
    logic [INST_ADDR_W-1:0] w_redirect_pc;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic [1:0]             w_count;
    logic [1:0]             w_count_after;
    logic [FIFO_W-1:0]      w_head;
    fetch_entry_t           w_push_entry;
    fetch_entry_t           w_head_entry;

`ifdef IF_REDIRECT_EN
    logic [INST_ADDR_W-1:0] r_disc_addr;

    assign w_redirect    = redirect_i;
    assign w_redirect_pc = align8(redirect_pc_i);
`else
    assign w_redirect    = 1'b0;
    assign w_redirect_pc = START_PC;
`endif

    // A response that coincides with a redirect belongs to the old path and is dropped.
    assign w_push        = (r_state == S_FETCH) & imem_ack_i & ~w_redirect;
    assign w_pop         = ~w_empty & ~stall_i & ~w_redirect;
    assign w_count_after = w_count + {1'b0, w_push} - {1'b0, w_pop};

    assign w_push_entry  = '{pc: r_pc, inst: imem_rdata_i};
    assign w_head_entry  = fetch_entry_t'(w_head);

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_redirect),
        .count     (w_count),
        .head      (w_head),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= START_PC;
        end else if (w_redirect) begin
            r_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

`ifdef IF_REDIRECT_EN
    // The abandoned request must keep its address until memory acknowledges it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disc_addr <= '0;
        end else if ((r_state == S_FETCH) && w_redirect && !imem_ack_i) begin
            r_disc_addr <= r_pc;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
`ifdef IF_REDIRECT_EN
                if (w_redirect) begin
                    w_next = imem_ack_i ? S_FETCH : S_DISCARD;
                end else
`endif
                if (w_push && (w_count_after == 2'd2)) begin
                    w_next = S_FULL;
                end
            end
            S_FULL: begin
                if (w_pop || w_redirect) begin
                    w_next = S_FETCH;
                end
            end
`ifdef IF_REDIRECT_EN
            S_DISCARD: begin
                if (imem_ack_i) begin
                    w_next = S_FETCH;
                end
            end
`endif
            default: begin
                w_next = S_BOOT;
            end
        endcase
    end

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        case (r_state)
            S_FETCH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = r_pc;
            end
`ifdef IF_REDIRECT_EN
            S_DISCARD: begin
                imem_req_o  = 1'b1;
                imem_addr_o = r_disc_addr;
            end
`endif
            default: begin
                imem_req_o  = 1'b0;
                imem_addr_o = '0;
            end
        endcase
    end

    always_comb begin
        if_valid_o = ~w_empty;
        pc_o       = w_empty ? '0 : w_head_entry.pc;
        inst_o     = w_empty ? NOP_INST : w_head_entry.inst;
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed scoreboard bench for if_stage with a zero/variable-wait memory model
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [63:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] pc_o;
    logic [63:0] inst_o;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    logic [31:0] pop_log[$];
    int          n_assert;
    int          n_fail;
    int          n_pops;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
`ifdef IF_REDIRECT_EN
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0),
`endif
        .stall_i      (stall_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs and compare outputs at the negedge, then advance.
    task automatic tick(input logic ack_en, input logic stall);
        stall_i      = stall;
        imem_ack_i   = ack_en;
        imem_rdata_i = mem_word(imem_addr_o);
        chk("valid", {95'b0, if_valid_o}, {95'b0, sb.size() != 0});
        if (imem_req_o) chk("addr", {64'b0, imem_addr_o}, {64'b0, exp_addr});
        if (sb.size() == 0) begin
            chk("nop_out", {pc_o, inst_o}, 96'h0);
        end else begin
            chk("head", {pc_o, inst_o}, {sb[0].pc, sb[0].inst});
            if (!stall) begin
                pop_log.push_back(pc_o);
                void'(sb.pop_front());
                n_pops++;
            end
        end
        if (ack_en && imem_req_o) begin
            sb.push_back('{pc: exp_addr, inst: mem_word(exp_addr)});
            exp_addr = exp_addr + 32'd8;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        n_pops       = 0;
        exp_addr     = 32'h0;
        rst          = 1'b0;
        stall_i      = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 64'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req",   {95'b0, imem_req_o}, 96'h0);
        chk("rst_addr",  {64'b0, imem_addr_o}, 96'h0);
        chk("rst_valid", {95'b0, if_valid_o}, 96'h0);
        chk("rst_pc",    {64'b0, pc_o}, 96'h0);
        chk("rst_inst",  {32'b0, inst_o}, 96'h0);
        rst = 1'b1;

        // Boot cycle: request low, a stray ack is ignored
        chk("boot_req", {95'b0, imem_req_o}, 96'h0);
        tick(1'b1, 1'b0);

        // Zero-wait memory, no stall: one instruction per cycle
        n_pops = 0;
        pop_log.delete();
        repeat (12) tick(1'b1, 1'b0);
        chk("throughput", 96'(n_pops), 96'd11);
        chk("seq_pc0", {64'b0, pop_log[0]}, {64'b0, 32'h0});
        chk("seq_pc1", {64'b0, pop_log[1]}, {64'b0, 32'h8});
        chk("seq_pc2", {64'b0, pop_log[2]}, {64'b0, 32'h10});

        // Stall for 5 cycles: buffer fills, request drops, head frozen
        for (int i = 0; i < 5; i++) begin
            if (i > 0) chk("full_req", {95'b0, imem_req_o}, 96'h0);
            tick(1'b1, 1'b1);
        end
        chk("full_valid", {95'b0, if_valid_o}, 96'h1);
        repeat (6) tick(1'b1, 1'b0);

        // Reset mid-request with one entry buffered
        tick(1'b0, 1'b1);
        chk("pre_rst_req", {95'b0, imem_req_o}, 96'h1);
        rst = 1'b0;
        #1;
        chk("async_req",   {95'b0, imem_req_o}, 96'h0);
        chk("async_addr",  {64'b0, imem_addr_o}, 96'h0);
        chk("async_valid", {95'b0, if_valid_o}, 96'h0);
        chk("async_out",   {pc_o, inst_o}, 96'h0);
        sb.delete();
        exp_addr = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        chk("late_ack_req", {95'b0, imem_req_o}, 96'h0);
        tick(1'b1, 1'b0);
        chk("first_addr", {64'b0, imem_addr_o}, 96'h0);
        tick(1'b1, 1'b0);

        // Ack delayed 3 cycles: address held at 0x8, exactly one push
        for (int i = 0; i < 3; i++) begin
            chk("wait_addr", {64'b0, imem_addr_o}, {64'b0, 32'h8});
            chk("wait_req",  {95'b0, imem_req_o}, 96'h1);
            tick(1'b0, 1'b0);
        end
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);

        // Drain and confirm nothing is left or duplicated
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1'b0, 1'b0);
        chk("drained", 96'(sb.size()), 96'd0);
        chk("final_valid", {95'b0, if_valid_o}, 96'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
